// File: rtl/garage_door_ctrl.sv
// Garage-door motor controller: one push-button, up/down limit switches, obstruction sensor,
// stop/reverse on press, auto-reverse while closing, motion watchdog and optional auto-close.
module garage_door_ctrl #(
  parameter int unsigned TMO_W        = 16,
  parameter int unsigned MOVE_TIMEOUT = 50000,
  parameter int unsigned AUTO_CLOSE   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       active,
  input  logic       up_max,
  input  logic       dn_max,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       up_m,
  output logic       dn_m,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    STOPPED = 3'd3,
    FAULT   = 3'd4
  } state_t;

  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOVE_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] AC_LAST  = TMO_W'(AUTO_CLOSE - 1);
  localparam logic             AC_EN    = (AUTO_CLOSE != 0);

  state_t           state, state_nxt;
  dir_t             last_dir, last_dir_nxt;
  logic [TMO_W-1:0] cnt, cnt_nxt;
  logic             active_q;
  logic             cmd;
  logic             both_lim;

  assign cmd      = active & ~active_q;
  assign both_lim = up_max & dn_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_dir <= DIR_DN;
      cnt      <= '0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_dir <= last_dir_nxt;
      cnt      <= cnt_nxt;
      active_q <= active;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    case (state)
      IDLE: begin
        if (both_lim)                                           state_nxt = FAULT;
        else if (cmd && up_max)                                 state_nxt = MOVE_DN;
        else if (cmd)                                           state_nxt = MOVE_UP;
        else if (AC_EN && up_max && !obstruct && cnt == AC_LAST) state_nxt = MOVE_DN;
      end
      MOVE_UP: begin
        if (both_lim)             state_nxt = FAULT;
        else if (up_max)          state_nxt = IDLE;
        else if (cnt == TMO_LAST) state_nxt = FAULT;
        else if (cmd) begin
          state_nxt    = STOPPED;
          last_dir_nxt = DIR_UP;
        end
      end
      MOVE_DN: begin
        if (both_lim)     state_nxt = FAULT;
        else if (dn_max)  state_nxt = IDLE;
        else if (obstruct) begin
          state_nxt    = MOVE_UP;
          last_dir_nxt = DIR_UP;
        end
        else if (cnt == TMO_LAST) state_nxt = FAULT;
        else if (cmd) begin
          state_nxt    = STOPPED;
          last_dir_nxt = DIR_DN;
        end
      end
      STOPPED: begin
        if (cmd) state_nxt = (last_dir == DIR_UP) ? MOVE_DN : MOVE_UP;
      end
      FAULT: begin
        if (fault_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the counter only runs as the auto-close timer (door up, beam clear)
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        MOVE_UP, MOVE_DN: if (cnt != '1) cnt_nxt = cnt + 1'b1;
        IDLE: begin
          if (up_max && !obstruct) begin
            if (cnt != '1) cnt_nxt = cnt + 1'b1;
          end else begin
            cnt_nxt = '0;
          end
        end
        default: cnt_nxt = cnt;
      endcase
    end
  end

  assign up_m    = (state == MOVE_UP);
  assign dn_m    = (state == MOVE_DN);
  assign fault   = (state == FAULT);
  assign state_o = state;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Directed bench for garage_door_ctrl: stimulus queues expected state per cycle,
// a negedge monitor pops and compares the decoded outputs.
module tb_garage_door_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_DN = 3'd2, S_STOP = 3'd3, S_FLT = 3'd4;

  typedef logic [8*16-1:0] name_t;
  typedef struct {
    int unsigned tag;
    logic [2:0]  st;
    name_t       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic active = 1'b0, up_max = 1'b0, dn_max = 1'b0, obstruct = 1'b0, fault_clr = 1'b0;
  logic up_m, dn_m, fault;
  logic [2:0] state_o;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t sb[$];

  garage_door_ctrl #(.TMO_W(8), .MOVE_TIMEOUT(20), .AUTO_CLOSE(10)) dut (
    .clk(clk), .reset_n(reset_n), .active(active), .up_max(up_max), .dn_max(dn_max),
    .obstruct(obstruct), .fault_clr(fault_clr), .up_m(up_m), .dn_m(dn_m),
    .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] exp_vec(input logic [2:0] st);
    return {st, st == S_UP, st == S_DN, st == S_FLT};
  endfunction

  task automatic compare(input name_t nm, input logic [5:0] got, input logic [5:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %0s: state/up/dn/fault got %b required %b", nm, got, want);
    end
  endtask

  task automatic tick_exp(input logic [2:0] st, input name_t nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = cyc;
    e.st = st;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      if (e.tag != cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %0s: expectation for cycle %0d seen at cycle %0d", e.name, e.tag, cyc);
      end else begin
        compare(e.name, {state_o, up_m, dn_m, fault}, exp_vec(e.st));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    dn_max = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare("reset_state", {state_o, up_m, dn_m, fault}, exp_vec(S_IDLE));
    reset_n = 1'b1;
    tick_exp(S_IDLE, "idle_after_rst");

    // 1: closed door, one press held 5 cycles gives a single up move
    active = 1'b1;
    tick_exp(S_UP, "t1_up");
    dn_max = 1'b0;
    for (int i = 0; i < 4; i++) tick_exp(S_UP, "t1_hold");
    active = 1'b0;
    for (int i = 0; i < 3; i++) tick_exp(S_UP, "t1_moving");
    up_max = 1'b1;
    tick_exp(S_IDLE, "t1_top");

    // 2: close, obstruction reverses, auto-close blocked by beam then fires 10 cycles after
    active = 1'b1;
    tick_exp(S_DN, "t2_dn");
    active = 1'b0;
    up_max = 1'b0;
    for (int i = 0; i < 3; i++) tick_exp(S_DN, "t2_closing");
    obstruct = 1'b1;
    tick_exp(S_UP, "t2_reverse");
    obstruct = 1'b0;
    for (int i = 0; i < 2; i++) tick_exp(S_UP, "t2_reopening");
    up_max = 1'b1;
    tick_exp(S_IDLE, "t2_top");
    obstruct = 1'b1;
    for (int i = 0; i < 12; i++) tick_exp(S_IDLE, "t2_ac_blocked");
    obstruct = 1'b0;
    for (int i = 0; i < 9; i++) tick_exp(S_IDLE, "t2_ac_wait");
    tick_exp(S_DN, "t2_autoclose");
    up_max = 1'b0;
    tick_exp(S_DN, "t2_ac_closing");
    dn_max = 1'b1;
    tick_exp(S_IDLE, "t2_closed");

    // 3: stop mid-travel and reverse on each subsequent press
    active = 1'b1;
    tick_exp(S_UP, "t3_up");
    active = 1'b0;
    dn_max = 1'b0;
    for (int i = 0; i < 4; i++) tick_exp(S_UP, "t3_moving");
    active = 1'b1;
    tick_exp(S_STOP, "t3_stop_up");
    active = 1'b0;
    for (int i = 0; i < 2; i++) tick_exp(S_STOP, "t3_stopped");
    active = 1'b1;
    tick_exp(S_DN, "t3_rev_dn");
    active = 1'b0;
    for (int i = 0; i < 2; i++) tick_exp(S_DN, "t3_closing");
    active = 1'b1;
    tick_exp(S_STOP, "t3_stop_dn");
    active = 1'b0;
    tick_exp(S_STOP, "t3_stopped2");
    active = 1'b1;
    tick_exp(S_UP, "t3_rev_up");
    active = 1'b0;

    // 4: no limit reached, 20 cycles of up drive then fault
    for (int i = 0; i < 19; i++) tick_exp(S_UP, "t4_running");
    tick_exp(S_FLT, "t4_timeout");
    active = 1'b1;
    tick_exp(S_FLT, "t4_press_ign");
    active = 1'b0;
    tick_exp(S_FLT, "t4_held");
    active = 1'b1;
    tick_exp(S_FLT, "t4_press_ign2");
    active = 1'b0;
    fault_clr = 1'b1;
    tick_exp(S_IDLE, "t4_clr");
    fault_clr = 1'b0;
    tick_exp(S_IDLE, "t4_idle");

    // 5: both limits fault from IDLE and MOVE_DN; async reset mid-close
    up_max = 1'b1;
    dn_max = 1'b1;
    tick_exp(S_FLT, "t5_both_idle");
    up_max = 1'b0;
    dn_max = 1'b0;
    fault_clr = 1'b1;
    tick_exp(S_IDLE, "t5_clr1");
    fault_clr = 1'b0;
    up_max = 1'b1;
    active = 1'b1;
    tick_exp(S_DN, "t5_dn1");
    active = 1'b0;
    up_max = 1'b0;
    tick_exp(S_DN, "t5_closing1");
    up_max = 1'b1;
    dn_max = 1'b1;
    tick_exp(S_FLT, "t5_both_dn");
    up_max = 1'b0;
    dn_max = 1'b0;
    fault_clr = 1'b1;
    tick_exp(S_IDLE, "t5_clr2");
    fault_clr = 1'b0;
    up_max = 1'b1;
    active = 1'b1;
    tick_exp(S_DN, "t5_dn2");
    active = 1'b0;
    up_max = 1'b0;
    tick_exp(S_DN, "t5_closing2");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    compare("t5_async_rst", {state_o, up_m, dn_m, fault}, exp_vec(S_IDLE));
    @(posedge clk);
    #1;
    compare("t5_rst_held", {state_o, up_m, dn_m, fault}, exp_vec(S_IDLE));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick_exp(S_IDLE, "t5_no_motion");

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
